// File: rtl/ex_stage.sv
// Execute stage: combinational ALU feeding a main/skid output buffer with a
// valid/ready handshake on both sides; owns the APSR flag register.
module ex_stage #(
  parameter int DATA_WIDTH  = 16,
  parameter int ALUOP_WIDTH = 4,
  parameter int APSR_WIDTH  = 3,
  parameter int RD_WIDTH    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ALUOP_WIDTH-1:0] in_op,
  input  logic [DATA_WIDTH-1:0]  in_a,
  input  logic [DATA_WIDTH-1:0]  in_b,
  input  logic [RD_WIDTH-1:0]    in_rd,
  input  logic                   in_wr_en,
  input  logic                   in_flags_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_result,
  output logic [APSR_WIDTH-1:0]  out_apsr,
  output logic [RD_WIDTH-1:0]    out_rd,
  output logic                   out_wr_en,
  input  logic                   flush,
  input  logic                   psr_wr_en,
  input  logic [APSR_WIDTH-1:0]  psr_wdata,
  output logic [APSR_WIDTH-1:0]  psr
);

  localparam int C_BIT = 0;
  localparam int Z_BIT = 1;
  localparam int N_BIT = 2;

  typedef enum logic [ALUOP_WIDTH-1:0] {
    OP_ADD  = ALUOP_WIDTH'(0),
    OP_ADDC = ALUOP_WIDTH'(1),
    OP_SUB  = ALUOP_WIDTH'(2),
    OP_SUBC = ALUOP_WIDTH'(3),
    OP_NAND = ALUOP_WIDTH'(4),
    OP_NOR  = ALUOP_WIDTH'(5),
    OP_XOR  = ALUOP_WIDTH'(6),
    OP_XNOR = ALUOP_WIDTH'(7)
  } alu_op_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [APSR_WIDTH-1:0] apsr;
    logic [RD_WIDTH-1:0]   rd;
    logic                  wr_en;
  } entry_t;

  entry_t                main_q, skid_q, new_entry;
  logic                  main_valid, skid_valid;
  logic [APSR_WIDTH-1:0] psr_q;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [APSR_WIDTH-1:0] alu_flags;
  logic                  alu_c, alu_known;
  logic                  accept;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    sum       = '0;
    alu_res   = in_a;
    alu_c     = 1'b0;
    alu_known = 1'b1;
    case (alu_op_e'(in_op))
      OP_ADD: begin
        sum     = {1'b0, in_a} + {1'b0, in_b};
        alu_res = sum[DATA_WIDTH-1:0];
        alu_c   = sum[DATA_WIDTH];
      end
      OP_ADDC: begin
        sum     = {1'b0, in_a} + {1'b0, in_b} + {{DATA_WIDTH{1'b0}}, psr_q[C_BIT]};
        alu_res = sum[DATA_WIDTH-1:0];
        alu_c   = sum[DATA_WIDTH];
      end
      OP_SUB:  alu_res = in_a - in_b;
      OP_SUBC: alu_res = in_a - in_b - {{(DATA_WIDTH-1){1'b0}}, psr_q[C_BIT]};
      OP_NAND: alu_res = ~(in_a & in_b);
      OP_NOR:  alu_res = ~(in_a | in_b);
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_XNOR: alu_res = ~(in_a ^ in_b);
      default: alu_known = 1'b0;
    endcase

    // Unassigned opcodes pass operand a through and leave the flags as-is.
    alu_flags = psr_q;
    if (alu_known) begin
      alu_flags        = '0;
      alu_flags[C_BIT] = alu_c;
      alu_flags[Z_BIT] = (alu_res == '0);
      alu_flags[N_BIT] = alu_res[DATA_WIDTH-1];
    end
  end

  assign new_entry = '{result: alu_res, apsr: alu_flags, rd: in_rd, wr_en: in_wr_en};

  // in_ready comes straight from the skid flop, so it is registered.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order. The payload
      // registers are reset too so out_* read zero after reset.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      psr_q      <= '0;
    end else begin
      // An external write wins over the instruction's own flag update.
      if (psr_wr_en)                psr_q <= psr_wdata;
      else if (accept && in_flags_en) psr_q <= alu_flags;

      if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (accept) begin
        // Skid is always empty here because accept implies in_ready.
        if (main_valid && !out_ready) begin
          skid_q     <= new_entry;
          skid_valid <= 1'b1;
        end else begin
          main_q     <= new_entry;
          main_valid <= 1'b1;
        end
      end else if (main_valid && out_ready) begin
        if (skid_valid) begin
          main_q     <= skid_q;
          skid_valid <= 1'b0;
        end else begin
          main_valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid  = main_valid;
  assign out_result = main_q.result;
  assign out_apsr   = main_q.apsr;
  assign out_rd     = main_q.rd;
  assign out_wr_en  = main_q.wr_en;
  assign psr        = psr_q;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute pipeline stage of the CPU, between register-read/decode (upstream) and writeback (downstream).
- Registers each accepted instruction's ALU result and flags, and owns the architectural APSR flag register that the ALU reads for carry-in.
- Has a valid/ready handshake on both sides and a 2-entry output buffer (main + skid) for full throughput under backpressure.
- Supports pipeline flush and an external APSR write port.

Parameters:
- DATA_WIDTH, 16, operand/result width.
- ALUOP_WIDTH, 4, ALU operation code width.
- APSR_WIDTH, 3, flag width; bit 0 = CARRY, bit 1 = ZERO, bit 2 = NEG.
- RD_WIDTH, 3, destination register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept (registered).
- in_op  in  ALUOP_WIDTH  operation.
- in_a  in  DATA_WIDTH  first operand.
- in_b  in  DATA_WIDTH  second operand.
- in_rd  in  RD_WIDTH  destination register.
- in_wr_en  in  1  instruction writes in_rd.
- in_flags_en  in  1  instruction updates APSR.
- out_valid  out  1  result valid to writeback.
- out_ready  in  1  writeback accepts.
- out_result  out  DATA_WIDTH  registered result.
- out_apsr  out  APSR_WIDTH  flags produced by that instruction.
- out_rd  out  RD_WIDTH  destination, passed through.
- out_wr_en  out  1  write enable, passed through.
- flush  in  1  discard all in-flight entries.
- psr_wr_en  in  1  external APSR write.
- psr_wdata  in  APSR_WIDTH  external APSR value.
- psr  out  APSR_WIDTH  current APSR register.

Behaviour:
- Reset (rst_n=0 at edge):
  - out_valid=0, skid valid=0, in_ready=1, psr=0.
  - out_result, out_apsr, out_rd, out_wr_en = 0.
  - While rst_n=0, inputs are ignored and nothing is accepted.
  - Reset mid-operation drops all entries; psr returns to 0.
- Accept condition: in_valid & in_ready & ~flush.
- ALU evaluation: combinational on in_a, in_b, in_op and the current psr. Latency is 1 cycle: the entry is visible on out_* the edge after accept when the main register is free.
- Operation encoding:
  - 0 ADD: {C,res}=a+b.
  - 1 ADDC: {C,res}=a+b+psr.C.
  - 2 SUB: res=a-b, C=0.
  - 3 SUBC: res=a-b-psr.C, C=0.
  - 4 NAND, 5 NOR, 6 XOR, 7 XNOR: C=0.
  - 8-15 (default): res=a, flags=psr.
  - For all operations except default: Z=(res==0), N=res[DATA_WIDTH-1]. All arithmetic is modulo 2^DATA_WIDTH.
- APSR update at accept edge:
  - If in_flags_en, psr <= ALU flags. The next accepted instruction sees the new carry (back-to-back ADD/ADDC is correct).
  - psr_wr_en has priority: psr <= psr_wdata, and the same-cycle instruction flag update is discarded. The instruction itself is still accepted.
  - flush does not alter psr.
- Buffering: main register (out_*) plus one skid entry; strict FIFO order.
  - Accept when main empty, or main draining (out_ready=1) with skid empty: entry goes to main.
  - Accept when main valid & out_ready=0: entry goes to skid. in_ready=0 from the next cycle.
  - Main drains while skid valid: skid moves to main, skid empties, in_ready=1 next cycle.
  - in_ready = ~skid_valid (registered), so at most 2 entries are held.
  - out_* stay stable while out_valid & ~out_ready.
- Flush (synchronous, rst_n=1):
  - Next cycle out_valid=0, skid empty, in_ready=1.
  - A same-cycle in_valid is not accepted and does not touch psr.
  - psr_wr_en is still honoured during flush.

Test Plan:
1. ADD a=0xFFFF, b=0x0001, flags_en=1 -> out_result=0x0000, out_apsr=3'b011, psr=3'b011. Next cycle ADDC a=0x0001, b=0x0001, flags_en=1 -> out_result=0x0003, psr=3'b000.
2. SUB a=0x0003, b=0x0005, flags_en=0, psr=3'b001 -> out_result=0xFFFE, out_apsr=3'b100, psr stays 3'b001. Op=9, a=0x1234 -> out_result=0x1234, out_apsr=psr.
3. out_ready=0, three back-to-back valid instructions (results 0x0001, 0x0002, 0x0003):
   - First in main, second in skid.
   - in_ready=0 the cycle after the second is accepted; third is held.
   - out_ready=1 -> outputs 0x0001, 0x0002, 0x0003 in order with no loss or duplication.
4. ADD 0x8000+0x8000 with flags_en=1, same cycle psr_wr_en=1, psr_wdata=3'b100 -> psr=3'b100, out_result=0x0000, out_apsr=3'b011.
5. Both entries held, flush=1 with in_valid=1 (XOR, flags_en=1) -> next cycle out_valid=0, in_ready=1, psr unchanged, XOR never appears.
6. rst_n=0 for one cycle while out_valid=1 and psr=3'b111 -> next cycle out_valid=0, in_ready=1, psr=0. in_valid during reset is ignored.
